dac_spi_tx: RTL
===============

# dac_spi_tx

Serial DAC driver sitting directly downstream of the audio `processor` stage. It takes the 10-bit offset-binary sample that stage registers on `sysclk` and ships it to an MCP4911 10-bit DAC as one 16-bit SPI write frame. The frame uses SPI mode 0,0 and is followed by an LDAC strobe, so the analogue output updates once per sample.

## Interface
- `CLK_DIV`, default 25: sysclk cycles per SCK half-period; legal range 2..255; SCK = sysclk/(2·CLK_DIV), which gives 1 MHz at 50 MHz.
- `CTRL`, default 4'b0011: MCP4911 control nibble {write=0, BUF=0, GA_n=1 (1x gain), SHDN_n=1 (active)}.
- `sysclk`, in, 1: system clock; all logic is on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `data_in`, in, 10: DAC code; offset binary, 0x200 = mid-scale.
- `load`, in, 1: single-cycle strobe requesting a frame for the current `data_in`.
- `dac_cs_n`, out, 1: chip select, active low.
- `dac_sck`, out, 1: serial clock; idles low.
- `dac_sdi`, out, 1: serial data, MSB first.
- `dac_ldac_n`, out, 1: latch strobe, active low.
- `busy`, out, 1: high while a frame is in progress.
- `done`, out, 1: one-cycle pulse at the end of each frame.

## Operation
- Frame word: {CTRL, data_in[9:0], 2'b00}, 16 bits. `data_in` is captured on the accepting edge and is not re-sampled during the frame.
- FSM states:
  - IDLE: `load`=1 and not `reset` → SHIFT. Capture the word, set `dac_cs_n`=0, drive `dac_sdi`=bit15, `busy`=1.
  - SHIFT: 32 half-periods. `dac_sck` toggles at the end of each half-period. `dac_sdi` advances to the next bit on every SCK falling edge; the DAC samples on the rising edge. After the 32nd half-period: `dac_sck`=0, `dac_sdi`=0, `dac_cs_n`=1 → CSHI.
  - CSHI: 1 half-period with CS high → LDAC, `dac_ldac_n`=0.
  - LDAC: 1 half-period, then `dac_ldac_n`=1, `done`=1 for one cycle → IDLE, `busy`=0.
- Counters: half-period counter is 8-bit and counts 0..CLK_DIV-1; bit counter is 5-bit and counts 0..31.
- `load` while `busy`=1 is ignored; the sample is dropped. See Configuration for the alternative.
- `reset` takes priority over all inputs. It aborts any frame on the next edge; the outputs then take their reset values and the FSM returns to IDLE.
- Reset values: `dac_cs_n`=1, `dac_sck`=0, `dac_sdi`=0, `dac_ldac_n`=1, `busy`=0, `done`=0.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Edge references below are counted from E0, the edge that accepts `load`.
- After E0: `dac_cs_n`=0, `busy`=1, `dac_sdi`=bit15.
- SCK rising edge k (k=1..16) occurs after E0+(2k−1)·CLK_DIV; falling edge k occurs after E0+2k·CLK_DIV.
- `dac_cs_n` rises after E0+32·CLK_DIV.
- `dac_ldac_n` is low from E0+33·CLK_DIV to E0+34·CLK_DIV.
- `done`=1 and `busy`=0 after E0+34·CLK_DIV; `done` clears after the next edge.
- Frame period: 34·CLK_DIV cycles (850 at default), well inside the 5000-cycle 10 kHz sample interval.
- Earliest back-to-back acceptance: the first edge after `busy` falls.
- `load` coincident with the frame-ending edge is ignored, because `busy`=1 at that edge.

## Configuration
- `DAC_PEND_EN`:
  - Defined: adds a one-entry pending register. A `load` while `busy`=1 captures `data_in` there; a later load overwrites it (latest sample wins). At the frame-ending edge, if a sample is pending, the FSM goes directly to SHIFT with that word. `done` still pulses, `busy` stays 1, and the pending entry is cleared. This includes a `load` on the frame-ending edge itself. `reset` clears the pending entry.
  - Undefined: no pending register; a `load` while busy is dropped.

## Test plan
- Reset, then `data_in`=0x200 with a `load` pulse, CLK_DIV=4. Required: 16 SCK rising edges with SDI sampled = 0x3800; CS low for exactly 128 cycles; LDAC low for 4 cycles; `done` pulses at cycle 136.
- `data_in`=0x3FF, then `data_in`=0x000. Required: captured words 0x3FFC and 0x3000; SDI is 0 after the frame.
- Change `data_in` mid-frame. Required: transmitted word is unchanged.
- Second `load` 50 cycles into a frame:
  - Without macro: no second frame.
  - With macro: second frame begins on the same edge as `done`, with `busy` continuously high.
- Assert `reset` at cycle 60 of a frame. Required: next edge gives CS=1, SCK=0, SDI=0, LDAC=1, busy=0; a pending entry is discarded; a fresh `load` then produces a correct full frame.

Source files
------------

// File: rtl/dac_spi_tx_if.sv
// Sample/handshake side and DAC pin side of the MCP4911 serial driver.
interface dac_spi_tx_if;
  logic [9:0] data_in;
  logic       load;
  logic       busy;
  logic       done;
  logic       dac_cs_n;
  logic       dac_sck;
  logic       dac_sdi;
  logic       dac_ldac_n;

  modport master (
    output data_in, load,
    input  busy, done, dac_cs_n, dac_sck, dac_sdi, dac_ldac_n
  );

  modport slave (
    input  data_in, load,
    output busy, done, dac_cs_n, dac_sck, dac_sdi, dac_ldac_n
  );
endinterface

// File: rtl/dac_spi_tx.sv
// MCP4911 SPI write-frame driver (mode 0,0) with LDAC strobe per sample.
// Optional feature: define DAC_PEND_EN for a one-entry latest-wins pending sample.
module dac_spi_tx #(
  parameter int         CLK_DIV = 25,
  parameter logic [3:0] CTRL    = 4'b0011
) (
  input  logic          sysclk,
  input  logic          reset,
  dac_spi_tx_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, CSHI, LDAC} state_t;

  state_t      state, state_nxt;
  logic [7:0]  hcnt, hcnt_nxt;
  logic [4:0]  bcnt, bcnt_nxt;
  logic [15:0] shreg, shreg_nxt;
  logic        cs_n, cs_n_nxt;
  logic        sck, sck_nxt;
  logic        sdi, sdi_nxt;
  logic        ldac_n, ldac_n_nxt;
  logic        busy, busy_nxt;
  logic        done, done_nxt;

  logic        hp_end;
  logic        last_half;
  logic        frame_end;
  logic        pend_take;
  logic [15:0] new_word;
  logic [15:0] take_word;

  assign hp_end    = (hcnt == 8'(CLK_DIV - 1));
  assign last_half = (bcnt == 5'd31);
  assign frame_end = (state == LDAC) && hp_end;
  assign new_word  = {CTRL, bus.data_in, 2'b00};

`ifdef DAC_PEND_EN
  logic       pend_vld, pend_vld_nxt;
  logic [9:0] pend_data, pend_data_nxt;

  // A load on the frame-ending edge is newer than anything held, so it wins.
  assign pend_take = pend_vld | bus.load;
  assign take_word = {CTRL, (bus.load ? bus.data_in : pend_data), 2'b00};

  always_comb begin
    pend_vld_nxt  = pend_vld;
    pend_data_nxt = pend_data;
    if (frame_end && pend_take) begin
      pend_vld_nxt = 1'b0;
    end else if (busy && bus.load) begin
      pend_vld_nxt  = 1'b1;
      pend_data_nxt = bus.data_in;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      pend_vld  <= 1'b0;
      pend_data <= '0;
    end else begin
      pend_vld  <= pend_vld_nxt;
      pend_data <= pend_data_nxt;
    end
  end
`else
  assign pend_take = 1'b0;
  assign take_word = new_word;
`endif

  // State and registered outputs
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state  <= IDLE;
      hcnt   <= '0;
      bcnt   <= '0;
      shreg  <= '0;
      cs_n   <= 1'b1;
      sck    <= 1'b0;
      sdi    <= 1'b0;
      ldac_n <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      hcnt   <= hcnt_nxt;
      bcnt   <= bcnt_nxt;
      shreg  <= shreg_nxt;
      cs_n   <= cs_n_nxt;
      sck    <= sck_nxt;
      sdi    <= sdi_nxt;
      ldac_n <= ldac_n_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.load) state_nxt = SHIFT;
      SHIFT:   if (hp_end && last_half) state_nxt = CSHI;
      CSHI:    if (hp_end) state_nxt = LDAC;
      LDAC:    if (hp_end) state_nxt = pend_take ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the datapath and output registers
  always_comb begin
    hcnt_nxt   = hcnt;
    bcnt_nxt   = bcnt;
    shreg_nxt  = shreg;
    cs_n_nxt   = cs_n;
    sck_nxt    = sck;
    sdi_nxt    = sdi;
    ldac_n_nxt = ldac_n;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.load) begin
          shreg_nxt = new_word;
          sdi_nxt   = new_word[15];
          cs_n_nxt  = 1'b0;
          busy_nxt  = 1'b1;
          hcnt_nxt  = '0;
          bcnt_nxt  = '0;
        end
      end
      SHIFT: begin
        hcnt_nxt = hp_end ? 8'd0 : hcnt + 8'd1;
        if (hp_end) begin
          bcnt_nxt = bcnt + 5'd1;
          if (last_half) begin
            sck_nxt  = 1'b0;
            sdi_nxt  = 1'b0;
            cs_n_nxt = 1'b1;
          end else begin
            sck_nxt = ~sck;
            // Falling SCK: present the next bit for the DAC's rising-edge sample
            if (sck) begin
              shreg_nxt = {shreg[14:0], 1'b0};
              sdi_nxt   = shreg[14];
            end
          end
        end
      end
      CSHI: begin
        hcnt_nxt = hp_end ? 8'd0 : hcnt + 8'd1;
        if (hp_end) ldac_n_nxt = 1'b0;
      end
      LDAC: begin
        hcnt_nxt = hp_end ? 8'd0 : hcnt + 8'd1;
        if (hp_end) begin
          ldac_n_nxt = 1'b1;
          done_nxt   = 1'b1;
          if (pend_take) begin
            shreg_nxt = take_word;
            sdi_nxt   = take_word[15];
            cs_n_nxt  = 1'b0;
            bcnt_nxt  = '0;
            busy_nxt  = 1'b1;
          end else begin
            busy_nxt = 1'b0;
          end
        end
      end
      default: begin
        busy_nxt = 1'b0;
      end
    endcase
  end

  assign bus.dac_cs_n   = cs_n;
  assign bus.dac_sck    = sck;
  assign bus.dac_sdi    = sdi;
  assign bus.dac_ldac_n = ldac_n;
  assign bus.busy       = busy;
  assign bus.done       = done;

endmodule
